wbu_top_ysyx_23060136: RTL

WBU_TOP_YSYX_23060136 -- requirements
Module: wbu_top_ysyx_23060136

---
 rtl/wbu_top_ysyx_23060136.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wbu_top_ysyx_23060136.sv
// Write-back unit: takes MEM-stage results and drives the GPR/CSR write ports.
// It also produces the retire pulse and the sticky halt flag. Ecall takes two
// write cycles: mepc first, then mcause.
// Optional feature: define WBU_RETIRE_CNT_EN to build the retired-instruction counter.
module wbu_top_ysyx_23060136 (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_i_valid,
   input  logic [31:0] MEM_i_pc,
   input  logic [31:0] MEM_i_inst,
   input  logic        MEM_i_commit,
   input  logic [4:0]  MEM_i_rd,
   input  logic        MEM_i_write_gpr,
   input  logic        MEM_i_mem_to_reg,
   input  logic [31:0] MEM_i_alu_result,
   input  logic [31:0] MEM_i_mem_rdata,
   input  logic        MEM_i_write_csr,
   input  logic [2:0]  MEM_i_csr_rd,
   input  logic [31:0] MEM_i_csr_wdata,
   input  logic        MEM_i_rv32_ecall,
   input  logic        MEM_i_system_halt,
   output logic        WB_o_ready,
   output logic [4:0]  WB_o_rd,
   output logic        WB_o_RegWr,
   output logic [31:0] WB_o_rf_busW,
   output logic [2:0]  WB_o_csr_rd,
   output logic        WB_o_CSRWr,
   output logic [31:0] WB_o_csr_busW,
   output logic [31:0] WB_o_pc,
   output logic [31:0] WB_o_inst,
   output logic        WB_o_commit,
   output logic        WB_o_halt,
   output logic [31:0] WB_o_retire_cnt
);

   localparam logic [2:0]  CSR_NONE   = 3'd0;
   localparam logic [2:0]  CSR_MEPC   = 3'd3;
   localparam logic [2:0]  CSR_MCAUSE = 3'd4;
   localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

   typedef enum logic [1:0] {IDLE, WRITE, ECALL_CAUSE, HALT} state_t;

   state_t state;
   logic   accept;

   // ready is a pure decode of the state register, so it reads 1 while reset holds IDLE
   assign WB_o_ready = (state == IDLE) || (state == WRITE);
   assign accept     = MEM_i_valid & WB_o_ready;

   // FSM and all registered write-port outputs; write strobes default low every cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         WB_o_rd       <= '0;
         WB_o_RegWr    <= 1'b0;
         WB_o_rf_busW  <= '0;
         WB_o_csr_rd   <= '0;
         WB_o_CSRWr    <= 1'b0;
         WB_o_csr_busW <= '0;
         WB_o_pc       <= '0;
         WB_o_inst     <= '0;
         WB_o_commit   <= 1'b0;
         WB_o_halt     <= 1'b0;
      end else begin
         WB_o_RegWr  <= 1'b0;
         WB_o_CSRWr  <= 1'b0;
         WB_o_commit <= 1'b0;
         case (state)
            IDLE, WRITE: begin
               if (accept) begin
                  WB_o_pc     <= MEM_i_pc;
                  WB_o_inst   <= MEM_i_inst;
                  WB_o_commit <= MEM_i_commit;
                  if (MEM_i_system_halt) begin
                     // halt wins over ecall and still retires its own GPR/CSR write
                     state         <= HALT;
                     WB_o_halt     <= 1'b1;
                     WB_o_rd       <= MEM_i_rd;
                     WB_o_RegWr    <= MEM_i_write_gpr & (MEM_i_rd != 5'd0);
                     WB_o_rf_busW  <= MEM_i_mem_to_reg ? MEM_i_mem_rdata : MEM_i_alu_result;
                     WB_o_csr_rd   <= MEM_i_csr_rd;
                     WB_o_CSRWr    <= MEM_i_write_csr & (MEM_i_csr_rd != CSR_NONE);
                     WB_o_csr_busW <= MEM_i_csr_wdata;
                  end else if (MEM_i_rv32_ecall) begin
                     state         <= ECALL_CAUSE;
                     WB_o_rd       <= MEM_i_rd;
                     WB_o_csr_rd   <= CSR_MEPC;
                     WB_o_CSRWr    <= 1'b1;
                     WB_o_csr_busW <= MEM_i_pc;
                  end else begin
                     state         <= WRITE;
                     WB_o_rd       <= MEM_i_rd;
                     WB_o_RegWr    <= MEM_i_write_gpr & (MEM_i_rd != 5'd0);
                     WB_o_rf_busW  <= MEM_i_mem_to_reg ? MEM_i_mem_rdata : MEM_i_alu_result;
                     WB_o_csr_rd   <= MEM_i_csr_rd;
                     WB_o_CSRWr    <= MEM_i_write_csr & (MEM_i_csr_rd != CSR_NONE);
                     WB_o_csr_busW <= MEM_i_csr_wdata;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            ECALL_CAUSE: begin
               state         <= IDLE;
               WB_o_csr_rd   <= CSR_MCAUSE;
               WB_o_CSRWr    <= 1'b1;
               WB_o_csr_busW <= CAUSE_ECALL_M;
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef WBU_RETIRE_CNT_EN
   logic        commit_next;
   logic [31:0] retire_cnt;

   // counter advances on the same edge that raises WB_o_commit, keeping the two aligned
   assign commit_next = accept & MEM_i_commit;

   // retired-instruction counter, wraps naturally at 32 bits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retire_cnt <= '0;
      end else if (commit_next) begin
         retire_cnt <= retire_cnt + 32'd1;
      end
   end

   assign WB_o_retire_cnt = retire_cnt;
`else
   assign WB_o_retire_cnt = '0;
`endif

endmodule
